// File: rtl/lbuf_pkg.sv
// lbuf_pkg: shared types, defaults and forwarding helper for the ping-pong line buffer
package lbuf_pkg;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  localparam int DEF_TRANSP = 0;
  localparam int DEF_CLR_VAL = 0;
  // stage fields are sized for the widest supported buffer: AW <= 16, DW <= 32
  localparam int AW_MAX = 16;
  localparam int DW_MAX = 32;
  typedef struct packed {
    logic vld;
    logic [AW_MAX-1:0] ad;
    logic [DW_MAX-1:0] dt;
    logic bank;
  } stage_t;
  function automatic logic hit(stage_t w, stage_t r);
    return w.vld && w.ad == r.ad && w.bank == r.bank;
  endfunction
endpackage

// File: rtl/lbuf_bank.sv
// lbuf_bank: simple dual-port RAM, one write port and one registered read port, read-old on collision
module lbuf_bank #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          cl,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rq
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge cl) begin
    if (we) mem[wa] <= wd;
    rq <= mem[ra];
  end
endmodule

// File: rtl/lbuf_pingpong.sv
// lbuf_pingpong: double-buffered sprite line buffer; transparent/priority draw into one bank,
// clear-after-read scan-out from the other, init sweep after reset
module lbuf_pingpong
  import lbuf_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 8,
  parameter logic [DW-1:0] TRANSP = DW'(DEF_TRANSP),
  parameter logic [DW-1:0] CLR_VAL = DW'(DEF_CLR_VAL),
  parameter bit PRIO = 1'b0
) (
  input  logic          cl,
  input  logic          rst,
  input  logic          swap,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_ad,
  input  logic [DW-1:0] wr_dt,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_ad,
  output logic [DW-1:0] rd_dt,
  output logic          rd_vld,
  output logic          bank,
  output logic          busy
);
  state_t state;
  logic [AW-1:0] cnt;
  stage_t s0, s1, r0, r1;
  logic [DW-1:0] q [2];
  logic [DW-1:0] cur, rd_q, last;
  logic run, commit, unused;
  assign run = state == ST_RUN;
  // s1/r1 record last cycle's writes, which the read-old RAM output cannot yet show
  assign cur = hit(s1, s0) ? s1.dt[DW-1:0] : hit(r1, s0) ? r1.dt[DW-1:0] : q[s0.bank];
  assign rd_q = hit(r1, r0) ? r1.dt[DW-1:0] : hit(s1, r0) ? s1.dt[DW-1:0] : q[r0.bank];
  assign commit = s0.vld && s0.dt[DW-1:0] != TRANSP && (!PRIO || cur == TRANSP);
  assign rd_dt = r0.vld ? rd_q : last;
  assign rd_vld = r0.vld;
  assign unused = ^{s0, s1, r0, r1};
  always_ff @(posedge cl) begin
    if (rst) begin
      state <= ST_INIT;
      cnt <= '0;
      bank <= 1'b0;
      busy <= 1'b1;
      s0 <= '0;
      s1 <= '0;
      r0 <= '0;
      r1 <= '0;
      last <= '0;
    end else begin
      if (!run) begin
        cnt <= cnt + AW'(1);
        if (&cnt) begin
          state <= ST_RUN;
          busy <= 1'b0;
        end
      end
      bank <= bank ^ (run && swap);
      s0 <= '{vld: run && wr_en, ad: AW_MAX'(wr_ad), dt: DW_MAX'(wr_dt), bank: bank};
      s1 <= '{vld: commit, ad: s0.ad, dt: s0.dt, bank: s0.bank};
      r0 <= '{vld: run && rd_en, ad: AW_MAX'(rd_ad), dt: '0, bank: ~bank};
      r1 <= '{vld: r0.vld, ad: r0.ad, dt: DW_MAX'(CLR_VAL), bank: r0.bank};
      if (r0.vld) last <= rd_q;
    end
  end
  // draw and clear stages always target opposite banks, so each write port sees one user
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic sel, we;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    assign sel = commit && s0.bank == 1'(b);
    assign we = !rst && (!run || sel || (r0.vld && r0.bank == 1'(b)));
    assign wa = !run ? cnt : sel ? s0.ad[AW-1:0] : r0.ad[AW-1:0];
    assign wd = run && sel ? s0.dt[DW-1:0] : CLR_VAL;
    assign ra = bank == 1'(b) ? wr_ad : rd_ad;
    lbuf_bank #(.AW(AW), .DW(DW)) u_bank (
      .cl(cl),
      .we(we),
      .wa(wa),
      .wd(wd),
      .ra(ra),
      .rq(q[b])
    );
  end
endmodule

// File: tb/tb_lbuf_pingpong.sv
// tb_lbuf_pingpong: directed and random stimulus on PRIO=0 and PRIO=1 buffers, checked every
// cycle against a model that applies each cycle's read, write and swap in order
module tb_lbuf_pingpong;
  logic cl = 1'b0;
  logic rst, swap, wr_en, rd_en;
  logic [3:0] wr_ad, rd_ad;
  logic [7:0] wr_dt;
  logic [7:0] rd_dt [2];
  logic rd_vld [2];
  logic bank [2];
  logic busy [2];
  int pass_n = 0;
  int total_n = 0;
  logic [7:0] mem [2][2][16];
  logic m_bank, m_vld;
  logic [7:0] m_dt [2];
  int m_init = 0;

  always #5 cl = ~cl;

  lbuf_pingpong #(.AW(4), .DW(8), .TRANSP(8'h00), .CLR_VAL(8'h00), .PRIO(1'b0)) dut0 (
    .cl(cl), .rst(rst), .swap(swap), .wr_en(wr_en), .wr_ad(wr_ad), .wr_dt(wr_dt),
    .rd_en(rd_en), .rd_ad(rd_ad), .rd_dt(rd_dt[0]), .rd_vld(rd_vld[0]), .bank(bank[0]), .busy(busy[0])
  );
  lbuf_pingpong #(.AW(4), .DW(8), .TRANSP(8'h00), .CLR_VAL(8'h00), .PRIO(1'b1)) dut1 (
    .cl(cl), .rst(rst), .swap(swap), .wr_en(wr_en), .wr_ad(wr_ad), .wr_dt(wr_dt),
    .rd_en(rd_en), .rd_ad(rd_ad), .rd_dt(rd_dt[1]), .rd_vld(rd_vld[1]), .bank(bank[1]), .busy(busy[1])
  );

  task automatic chk(string nm, int p, logic [31:0] act, logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s dut%0d: got %0h want %0h at %0t", nm, p, act, exp, $time);
  endtask

  // advance the model by the current inputs, clock once, then compare all outputs
  task automatic step();
    if (rst) begin
      m_bank = 1'b0;
      m_vld = 1'b0;
      m_dt[0] = 8'h00;
      m_dt[1] = 8'h00;
      m_init = 16;
      foreach (mem[p, b, a]) mem[p][b][a] = 8'h00;
    end else if (m_init > 0) begin
      m_init--;
      m_vld = 1'b0;
    end else begin
      m_vld = rd_en;
      for (int p = 0; p < 2; p++) begin
        if (rd_en) begin
          m_dt[p] = mem[p][!m_bank][rd_ad];
          mem[p][!m_bank][rd_ad] = 8'h00;
        end
        if (wr_en && wr_dt != 8'h00 && (p == 0 || mem[p][m_bank][wr_ad] == 8'h00))
          mem[p][m_bank][wr_ad] = wr_dt;
      end
      if (swap) m_bank = !m_bank;
    end
    @(posedge cl);
    @(negedge cl);
    for (int p = 0; p < 2; p++) begin
      chk("busy", p, busy[p], m_init > 0);
      chk("bank", p, bank[p], m_bank);
      chk("rd_vld", p, rd_vld[p], m_vld);
      chk("rd_dt", p, rd_dt[p], m_dt[p]);
    end
  endtask

  task automatic op(bit r, bit s, bit we, int wa, int wd, bit re, int ra);
    rst = r;
    swap = s;
    wr_en = we;
    wr_ad = 4'(wa);
    wr_dt = 8'(wd);
    rd_en = re;
    rd_ad = 4'(ra);
    step();
  endtask

  // hand-computed expectation for the read issued in the last step
  task automatic lit(string nm, logic [7:0] e0, logic [7:0] e1);
    chk(nm, 0, {rd_vld[0], rd_dt[0]}, {1'b1, e0});
    chk(nm, 1, {rd_vld[1], rd_dt[1]}, {1'b1, e1});
  endtask

  task automatic wait_init(string nm);
    int n = 0;
    while (busy[0] && n < 40) begin
      op(0, 0, 0, 0, 0, 0, 0);
      n++;
    end
    chk(nm, 0, n, 16);
  endtask

  initial begin
    // 1: init sweep, then both banks read back clear
    repeat (3) op(1, 0, 0, 0, 0, 0, 0);
    wait_init("init_len");
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 16; a++) begin
        op(0, 0, 0, 0, 0, 1, a);
        lit("init_clr", 8'h00, 8'h00);
      end
      op(0, 1, 0, 0, 0, 0, 0);
    end
    // 2: transparency and back-to-back clear forwarding
    op(0, 0, 1, 5, 8'h3C, 0, 0);
    op(0, 0, 1, 5, 8'h00, 0, 0);
    op(0, 1, 0, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0, 1, 5);
    lit("transp_rd", 8'h3C, 8'h3C);
    op(0, 0, 0, 0, 0, 1, 5);
    lit("fwd_clr", 8'h00, 8'h00);
    // 3: priority with draw forwarding
    op(0, 0, 1, 7, 8'h11, 0, 0);
    op(0, 0, 1, 7, 8'h22, 0, 0);
    op(0, 1, 0, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0, 1, 7);
    lit("prio", 8'h22, 8'h11);
    // 4: write in the swap cycle lands in the pre-swap bank
    op(0, 1, 1, 2, 8'hAA, 0, 0);
    op(0, 1, 0, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0, 1, 2);
    lit("swap_other", 8'h00, 8'h00);
    op(0, 1, 0, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0, 1, 2);
    lit("swap_wr", 8'hAA, 8'hAA);
    // 5: concurrent draw and display at the same addresses
    for (int i = 0; i < 16; i++) op(0, 0, 1, i, 8'h80 + i, 0, 0);
    op(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      op(0, 0, 1, i, i + 1, 1, i);
      lit("conc_rd", 8'(8'h80 + i), 8'(8'h80 + i));
    end
    op(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      op(0, 0, 0, 0, 0, 1, i);
      lit("conc_drawn", 8'(i + 1), 8'(i + 1));
    end
    op(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      op(0, 0, 0, 0, 0, 1, i);
      lit("conc_cleared", 8'h00, 8'h00);
    end
    // 6: reset during a write burst
    for (int k = 0; k < 6; k++) op(0, k[0], 1, k, 8'h40 + k, 1, k);
    op(1, 0, 1, 3, 8'h55, 1, 3);
    for (int p = 0; p < 2; p++) begin
      chk("rst_bank", p, bank[p], 1'b0);
      chk("rst_vld", p, rd_vld[p], 1'b0);
      chk("rst_busy", p, busy[p], 1'b1);
    end
    wait_init("reinit_len");
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 16; a++) begin
        op(0, 0, 0, 0, 0, 1, a);
        lit("reinit_clr", 8'h00, 8'h00);
      end
      op(0, 1, 0, 0, 0, 0, 0);
    end
    // random traffic on a few addresses to stress forwarding across swaps
    for (int k = 0; k < 1500; k++)
      op($urandom_range(199) == 0, $urandom_range(4) == 0, $urandom_range(1) == 1,
         $urandom_range(3), ($urandom_range(3) == 0) ? 0 : $urandom_range(255),
         $urandom_range(1) == 1, $urandom_range(3));
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
